// File: rtl/wb_pkg.sv
// Shared widths and the pending-write entry record for the writeback queue.
package wb_pkg;
  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } entry_t;
endpackage

// File: rtl/wb_match.sv
// Newest-wins lookup of one read address over the pending queue entries
// and the register-file output register.
module wb_match
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic [REG_ADDR_W-1:0]      raddr,
  input  entry_t [DEPTH-1:0]         entries,
  input  logic [$clog2(DEPTH)-1:0]   head,
  input  logic                       rf_wen,
  input  logic [REG_ADDR_W-1:0]      rf_waddr,
  input  logic [DATA_W-1:0]          rf_wdata,
  output logic                       hit,
  output logic [DATA_W-1:0]          hdata
);
  localparam int PW = $clog2(DEPTH);

  logic [PW-1:0] idx;

  // Walk oldest to newest starting at the head so later matches override
  // earlier ones; the output register is the oldest candidate of all.
  always_comb begin
    hit   = 1'b0;
    hdata = '0;
    idx   = head;
    if (rf_wen && rf_waddr == raddr) begin
      hit   = 1'b1;
      hdata = rf_wdata;
    end
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (entries[idx].valid && entries[idx].addr == raddr) begin
        hit   = 1'b1;
        hdata = entries[idx].data;
      end
    end
    if (raddr == '0) begin
      hit   = 1'b0;
      hdata = '0;
    end
  end
endmodule

// File: rtl/writeback_queue.sv
// Merges load and ALU results into an in-order register-file write stream,
// with forwarding of pending values to two decode-stage read ports.
module writeback_queue
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mem_valid,
  output logic                         mem_ready,
  input  logic [REG_ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]            mem_data,
  input  logic                         alu_valid,
  output logic                         alu_ready,
  input  logic [REG_ADDR_W-1:0]        alu_addr,
  input  logic [DATA_W-1:0]            alu_data,
  output logic                         rf_wen,
  output logic [REG_ADDR_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]            rf_wdata,
  input  logic [REG_ADDR_W-1:0]        raddr0,
  input  logic [REG_ADDR_W-1:0]        raddr1,
  output logic                         hit0,
  output logic                         hit1,
  output logic [DATA_W-1:0]            hdata0,
  output logic [DATA_W-1:0]            hdata1,
  output logic [$clog2(DEPTH+1)-1:0]   count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  entry_t [DEPTH-1:0] entries;
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      alu_slot;
  logic               mem_en;
  logic               alu_en;
  logic               pop;

  // ALU readiness keeps one slot in reserve so a dual transfer always fits.
  assign mem_ready = count < CW'(DEPTH);
  assign alu_ready = count < CW'(DEPTH - 1);

  // Writes to r0 complete the handshake but never occupy a slot.
  assign mem_en   = mem_valid && mem_ready && (mem_addr != '0);
  assign alu_en   = alu_valid && alu_ready && (alu_addr != '0);
  assign pop      = count != '0;
  assign alu_slot = wr_ptr + PW'(mem_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entries  <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      if (pop) begin
        rf_wen                <= 1'b1;
        rf_waddr              <= entries[rd_ptr].addr;
        rf_wdata              <= entries[rd_ptr].data;
        entries[rd_ptr].valid <= 1'b0;
        rd_ptr                <= rd_ptr + PW'(1);
      end else begin
        rf_wen <= 1'b0;
      end
      if (mem_en) begin
        entries[wr_ptr] <= '{valid: 1'b1, addr: mem_addr, data: mem_data};
      end
      if (alu_en) begin
        entries[alu_slot] <= '{valid: 1'b1, addr: alu_addr, data: alu_data};
      end
      wr_ptr <= wr_ptr + PW'(mem_en) + PW'(alu_en);
      count  <= count + CW'(mem_en) + CW'(alu_en) - CW'(pop);
    end
  end

  wb_match #(.DEPTH(DEPTH)) u_match0 (
    .raddr    (raddr0),
    .entries  (entries),
    .head     (rd_ptr),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .hit      (hit0),
    .hdata    (hdata0)
  );

  wb_match #(.DEPTH(DEPTH)) u_match1 (
    .raddr    (raddr1),
    .entries  (entries),
    .head     (rd_ptr),
    .rf_wen   (rf_wen),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .hit      (hit1),
    .hdata    (hdata1)
  );
endmodule

// File: tb/tb_writeback_queue.sv
// Scoreboard bench for writeback_queue: a queue-level reference model
// predicts readiness, occupancy and forwarding; a monitor checks rf writes.
module tb_writeback_queue;
  localparam int DEPTH = 4;

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        mem_valid = 1'b0, alu_valid = 1'b0;
  logic        mem_ready, alu_ready;
  logic [4:0]  mem_addr = '0, alu_addr = '0;
  logic [31:0] mem_data = '0, alu_data = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  raddr0 = '0, raddr1 = '0;
  logic        hit0, hit1;
  logic [31:0] hdata0, hdata1;
  logic [2:0]  count;

  int tests = 0;
  int fails = 0;

  // Reference model: pending writes in age order plus the output register.
  ent_t        mq[$];
  ent_t        exp_q[$];
  logic        m_rf_wen = 1'b0;
  logic [4:0]  m_rf_addr = '0;
  logic [31:0] m_rf_data = '0;

  writeback_queue #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .raddr0    (raddr0),
    .raddr1    (raddr1),
    .hit0      (hit0),
    .hit1      (hit1),
    .hdata0    (hdata0),
    .hdata1    (hdata1),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Newest pending write to an address wins; the output register is last.
  function automatic void model_lookup(input logic [4:0] a, output logic h, output logic [31:0] d);
    h = 1'b0;
    d = '0;
    if (a == 5'd0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].addr == a) begin
        h = 1'b1;
        d = mq[i].data;
        return;
      end
    end
    if (m_rf_wen && m_rf_addr == a) begin
      h = 1'b1;
      d = m_rf_data;
    end
  endfunction

  // One clock cycle, entered and left just after a falling edge.
  task automatic apply_stimulus(input logic mv, input logic [4:0] ma, input logic [31:0] md,
                                input logic av, input logic [4:0] aa, input logic [31:0] ad,
                                input logic [4:0] r0, input logic [4:0] r1);
    logic        h;
    logic [31:0] d;
    logic        acc_m, acc_a;
    ent_t        e;
    check_output("mem_ready", mem_ready, (mq.size() < DEPTH) ? 1 : 0);
    check_output("alu_ready", alu_ready, (mq.size() < DEPTH - 1) ? 1 : 0);
    check_output("count", count, mq.size());
    check_output("rf_wen", rf_wen, m_rf_wen);
    check_output("rf_waddr", rf_waddr, m_rf_addr);
    check_output("rf_wdata", rf_wdata, m_rf_data);
    raddr0 = r0;
    raddr1 = r1;
    mem_valid = mv; mem_addr = ma; mem_data = md;
    alu_valid = av; alu_addr = aa; alu_data = ad;
    #1;
    model_lookup(r0, h, d);
    check_output("hit0", hit0, h);
    check_output("hdata0", hdata0, d);
    model_lookup(r1, h, d);
    check_output("hit1", hit1, h);
    check_output("hdata1", hdata1, d);
    acc_m = mv && (mq.size() < DEPTH);
    acc_a = av && (mq.size() < DEPTH - 1);
    @(posedge clk);
    if (mq.size() > 0) begin
      e = mq.pop_front();
      m_rf_wen  = 1'b1;
      m_rf_addr = e.addr;
      m_rf_data = e.data;
    end else begin
      m_rf_wen = 1'b0;
    end
    if (acc_m && ma != 5'd0) begin
      e.addr = ma; e.data = md;
      mq.push_back(e);
      exp_q.push_back(e);
    end
    if (acc_a && aa != 5'd0) begin
      e.addr = aa; e.data = ad;
      mq.push_back(e);
      exp_q.push_back(e);
    end
    @(negedge clk);
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic idle(input int n, input logic [4:0] r0, input logic [4:0] r1);
    for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0, 0, 0, r0, r1);
  endtask

  // Reset asserted mid-cycle, effects checked before any clock edge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    #1;
    check_output("rst_rf_wen", rf_wen, 0);
    check_output("rst_count", count, 0);
    check_output("rst_waddr", rf_waddr, 0);
    check_output("rst_wdata", rf_wdata, 0);
    check_output("rst_mem_ready", mem_ready, 1);
    check_output("rst_alu_ready", alu_ready, 1);
    mq.delete();
    exp_q.delete();
    m_rf_wen  = 1'b0;
    m_rf_addr = '0;
    m_rf_data = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Monitor: every register-file write must be the next expected entry.
  always @(negedge clk) begin
    ent_t e;
    if (rst_n && rf_wen) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL sb_unexpected: got write r%0d=0x%0h, expected no write", rf_waddr, rf_wdata);
      end else begin
        e = exp_q.pop_front();
        check_output("sb_waddr", rf_waddr, e.addr);
        check_output("sb_wdata", rf_wdata, e.data);
      end
    end
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Single load, forwarded until the register file commits it.
    apply_stimulus(1, 5'd3, 32'h11, 0, 0, 0, 5'd3, 5'd0);
    raddr0 = 5'd3;
    #1;
    check_output("req029_hit_queued", hit0, 1);
    apply_stimulus(0, 0, 0, 0, 0, 0, 5'd3, 5'd3);
    check_output("req029_wen", rf_wen, 1);
    check_output("req029_waddr", rf_waddr, 3);
    check_output("req029_wdata", rf_wdata, 32'h11);
    idle(2, 5'd3, 5'd3);

    // Same-cycle dual write to one register: ALU value is newer.
    apply_stimulus(1, 5'd5, 32'hA, 1, 5'd5, 32'hB, 5'd5, 5'd5);
    raddr1 = 5'd5;
    #1;
    check_output("req030_hdata", hdata1, 32'hB);
    idle(4, 5'd5, 5'd4);

    // Write to r0 is swallowed.
    apply_stimulus(0, 0, 0, 1, 5'd0, 32'hFFFF, 5'd0, 5'd0);
    check_output("req031_count", count, 0);
    idle(3, 5'd0, 5'd0);

    // Fill to three pending, then stream loads through the wrap point.
    apply_stimulus(1, 5'd1, 32'h101, 1, 5'd2, 32'h102, 5'd1, 5'd2);
    apply_stimulus(1, 5'd3, 32'h103, 1, 5'd4, 32'h104, 5'd3, 5'd4);
    check_output("req032_count3", count, 3);
    check_output("req032_alu_ready", alu_ready, 0);
    check_output("req032_mem_ready", mem_ready, 1);
    for (int i = 0; i < 10; i++)
      apply_stimulus(1, 5'(i % 31 + 1), 32'h200 + i, 1, 5'd9, 32'hDEAD, 5'(i % 31 + 1), 5'd9);
    idle(6, 5'd4, 5'd10);

    // Reset in the middle of a drain.
    apply_stimulus(1, 5'd6, 32'h61, 1, 5'd7, 32'h71, 5'd6, 5'd7);
    apply_stimulus(1, 5'd8, 32'h81, 1, 5'd9, 32'h91, 5'd8, 5'd9);
    apply_stimulus(1, 5'd10, 32'hA1, 0, 0, 0, 5'd10, 5'd6);
    check_output("req033_pre_count", count, 3);
    check_output("req033_pre_wen", rf_wen, 1);
    do_reset();
    idle(6, 5'd8, 5'd10);

    // Random traffic over a small register range to provoke many hits.
    for (int i = 0; i < 400; i++) begin
      apply_stimulus($urandom_range(0, 3) != 0, 5'($urandom_range(0, 7)), $urandom,
                     $urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                     5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      if (i == 200) do_reset();
    end
    idle(8, 5'd1, 5'd2);
    check_output("sb_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
